imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, word-index width of instruction memory; STARVE_MAX, default 4, max consecutive loader denials before forced loader grant.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports f_req input 1, f_addr input 32: fetch read request and byte address.
REQ-005 SHALL have ports f_gnt output 1, f_rvalid output 1, f_rdata output 32: fetch grant, read-data valid, read data.
REQ-006 SHALL have ports l_req input 1, l_we input 1, l_addr input 32, l_wdata input 32: loader/debug request, write enable, byte address, write data.
REQ-007 SHALL have ports l_gnt output 1, l_rvalid output 1, l_rdata output 32: loader grant, read-data valid, read data.
REQ-008 SHALL have ports mem_en output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output 32, mem_rdata input 32: single-port memory, read data valid one cycle after a read access.
REQ-009 SHALL have port fetch_stall  output  1  asserted when f_req is high and f_gnt is low.

Function
REQ-010 SHALL grant at most one requester per cycle; grants are combinational from current requests and registered state.
REQ-011 SHALL grant fetch when only f_req is high, loader when only l_req is high, none when neither is high.
REQ-012 SHALL, when both request, grant fetch unless starve_cnt equals STARVE_MAX, in which case it grants the loader.
REQ-013 SHALL increment starve_cnt (saturating at STARVE_MAX) each cycle l_req is high and l_gnt is low, and clear it in any cycle l_gnt is high.
REQ-014 SHALL drive mem_en = f_gnt | l_gnt, mem_we = l_gnt & l_we, mem_addr = granted address bits [ADDR_W+1:2], mem_wdata = l_wdata.
REQ-015 SHALL ignore address bits [1:0] and bits above ADDR_W+1, so out-of-range addresses wrap modulo 2^ADDR_W words.
REQ-016 SHALL hold a registered response owner, one of NONE, FETCH, LOAD: FETCH after a fetch grant, LOAD after a loader read grant, NONE after idle or a loader write.
REQ-017 SHALL assert f_rvalid exactly when owner is FETCH and l_rvalid exactly when owner is LOAD, with read latency exactly one cycle from grant.
REQ-018 SHALL drive f_rdata and l_rdata from mem_rdata when the matching rvalid is high, otherwise 32'h0.
REQ-019 SHALL never generate rvalid for a loader write.
REQ-020 SHALL support back-to-back grants every cycle, including alternating owners, with no bubble.

Reset
REQ-021 SHALL, while rst is high, force starve_cnt = 0 and owner = NONE; all grants, mem_en, mem_we, rvalids, rdata and fetch_stall low or zero (fetch_stall may follow f_req).
REQ-022 SHALL drop any in-flight read response when reset asserts mid-operation; no rvalid is issued after release for pre-reset grants.

Configuration
REQ-023 SHALL support macro IMEM_ARBITER_LOCK_EN; when defined it adds port l_lock (input, 1) and a LOCKED state.
REQ-024 With IMEM_ARBITER_LOCK_EN defined, the block SHALL enter LOCKED when l_gnt and l_lock are both high; in LOCKED the loader has exclusive access, fetch is never granted, and l_gnt = l_req.
REQ-025 With IMEM_ARBITER_LOCK_EN defined, the block SHALL exit LOCKED on the first cycle l_lock is low; reset clears LOCKED.
REQ-026 Without IMEM_ARBITER_LOCK_EN, the l_lock port and LOCKED state SHALL be absent and arbitration follows REQ-011..013 only.

Structure
REQ-027 SHALL take the owner encoding (NONE/FETCH/LOAD) and the default ADDR_W/STARVE_MAX constants from the shared core package.
REQ-028 SHALL be a single module; no sub-module is warranted.

Verification
REQ-029 Test 1: fetch-only reads at f_addr 0x0, 0x4, 0x8 on consecutive cycles -> mem_addr 0, 1, 2; f_rvalid high one cycle later each, with f_rdata = mem contents.
REQ-030 Test 2: f_req and l_req held high continuously with STARVE_MAX = 4 -> 4 fetch grants, then 1 loader grant, then the pattern repeats; fetch_stall high on each loader-grant cycle.
REQ-031 Test 3: loader write l_addr 0x10, l_wdata 0xDEADBEEF, then fetch read of 0x10 -> mem_we high with mem_addr 4; next fetch returns 0xDEADBEEF; l_rvalid never asserts.
REQ-032 Test 4: l_addr 0x1004 with ADDR_W = 10 -> mem_addr 1 (wrap).
REQ-033 Test 5: rst asserted in the cycle after a fetch grant -> f_rvalid stays low; starve_cnt = 0 after release.
REQ-034 Test 6 (IMEM_ARBITER_LOCK_EN defined): loader granted with l_lock high, f_req held high for 10 cycles -> f_gnt low throughout; first fetch grant in the cycle l_lock drops.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared core definitions for the instruction-memory arbiter: response owner
// encoding and the default geometry/fairness constants.
package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/imem_arbiter.sv
// Two-requester arbiter (instruction fetch vs loader/debug) in front of a single-port
// instruction memory. Optional loader lock is enabled by defining IMEM_ARBITER_LOCK_EN.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
`ifdef IMEM_ARBITER_LOCK_EN
    input  logic              l_lock,
`endif
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              fetch_stall
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;
    owner_t           owner;
    owner_t           owner_nxt;
    logic             lock_hold;

    // Byte offset and out-of-range word bits are deliberately dropped (address wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[1:0], f_addr[31:ADDR_W+2],
                                l_addr[1:0], l_addr[31:ADDR_W+2]};

`ifdef IMEM_ARBITER_LOCK_EN
    logic locked;

    // Lock only holds while l_lock stays high; dropping it restores normal arbitration that cycle.
    assign lock_hold = locked & l_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked <= 1'b0;
        end else begin
            locked <= l_lock & (lock_hold | l_gnt);
        end
    end
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst) begin
            if (lock_hold) begin
                l_gnt = l_req;
            end else if (f_req && l_req) begin
                if (starve_cnt == CNT_W'(STARVE_MAX)) begin
                    l_gnt = 1'b1;
                end else begin
                    f_gnt = 1'b1;
                end
            end else begin
                f_gnt = f_req;
                l_gnt = l_req;
            end
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (l_gnt) begin
            starve_nxt = '0;
        end else if (l_req && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    // Loader writes return nothing, so they leave the response slot empty.
    always_comb begin
        owner_nxt = OWN_NONE;
        if (l_gnt) begin
            owner_nxt = l_we ? OWN_NONE : OWN_LOAD;
        end else if (f_gnt) begin
            owner_nxt = OWN_FETCH;
        end
    end

    always_comb begin
        f_rvalid = (owner == OWN_FETCH);
        l_rvalid = (owner == OWN_LOAD);
        f_rdata  = f_rvalid ? mem_rdata : 32'h0;
        l_rdata  = l_rvalid ? mem_rdata : 32'h0;
    end

    assign mem_en      = f_gnt | l_gnt;
    assign mem_we      = l_gnt & l_we;
    assign mem_addr    = l_gnt ? l_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];
    assign mem_wdata   = l_wdata;
    assign fetch_stall = f_req & ~f_gnt;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_imem_arbiter;

    localparam int ADDR_W     = 10;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;
`ifdef IMEM_ARBITER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              l_req;
    logic              l_we;
    logic [31:0]       l_addr;
    logic [31:0]       l_wdata;
    logic              l_lock;
    logic              l_gnt;
    logic              l_rvalid;
    logic [31:0]       l_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              fetch_stall;

    int checks = 0;
    int errors = 0;

    imem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
`ifdef IMEM_ARBITER_LOCK_EN
        .l_lock(l_lock),
`endif
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fetch_stall(fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
    endfunction

    // Environment memory: single port, read data registered one cycle after the access.
    logic [31:0] env_mem [DEPTH];
    logic        written [DEPTH];
    logic        env_clr;
    logic [31:0] env_rdata;
    assign mem_rdata = env_rdata;

    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < DEPTH; i++) written[i] <= 1'b0;
        end else if (mem_en) begin
            if (mem_we) begin
                env_mem[mem_addr] <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                env_rdata <= written[mem_addr] ? env_mem[mem_addr] : init_val(int'(mem_addr));
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic lr,
                                 input logic we, input logic [31:0] la, input logic [31:0] wd,
                                 input logic lk, input logic r);
        @(posedge clk);
        #1;
        f_req   = fr;
        f_addr  = fa;
        l_req   = lr;
        l_we    = we;
        l_addr  = la;
        l_wdata = wd;
        l_lock  = lk;
        rst     = r;
        #1;
    endtask

    // Reference model: grant rules, starvation counter, pending response and shadow memory.
    logic [31:0] ref_mem [DEPTH];
    bit          model_init = 1'b0;
    int          starve_m   = 0;
    int          pend_kind  = 0;
    logic [31:0] pend_data  = 32'h0;
    bit          locked_m   = 1'b0;

    function automatic int word_of(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    always @(negedge clk) begin
        bit e_fg, e_lg, lock_now;
        int fa_w, la_w;
        if (!model_init) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
            model_init = 1'b1;
        end
        e_fg = 1'b0;
        e_lg = 1'b0;
        lock_now = LOCK_EN && locked_m && l_lock;
        fa_w = word_of(f_addr);
        la_w = word_of(l_addr);
        if (!rst) begin
            if (lock_now) e_lg = l_req;
            else if (f_req && l_req) begin
                if (starve_m == STARVE_MAX) e_lg = 1'b1;
                else e_fg = 1'b1;
            end else begin
                e_fg = f_req;
                e_lg = l_req;
            end
        end

        checkOutput("f_gnt", 32'(f_gnt), 32'(e_fg));
        checkOutput("l_gnt", 32'(l_gnt), 32'(e_lg));
        checkOutput("mem_en", 32'(mem_en), 32'(e_fg | e_lg));
        checkOutput("mem_we", 32'(mem_we), 32'(e_lg & l_we));
        if (e_lg) checkOutput("mem_addr", 32'(mem_addr), 32'(la_w));
        else if (e_fg) checkOutput("mem_addr", 32'(mem_addr), 32'(fa_w));
        if (e_lg && l_we) checkOutput("mem_wdata", mem_wdata, l_wdata);
        if (!rst) checkOutput("fetch_stall", 32'(fetch_stall), 32'(f_req & !e_fg));
        checkOutput("f_rvalid", 32'(f_rvalid), 32'(!rst && pend_kind == 1));
        checkOutput("l_rvalid", 32'(l_rvalid), 32'(!rst && pend_kind == 2));
        checkOutput("f_rdata", f_rdata, (!rst && pend_kind == 1) ? pend_data : 32'h0);
        checkOutput("l_rdata", l_rdata, (!rst && pend_kind == 2) ? pend_data : 32'h0);

        if (rst) begin
            starve_m  = 0;
            pend_kind = 0;
            locked_m  = 1'b0;
        end else begin
            if (e_lg) starve_m = 0;
            else if (l_req && starve_m < STARVE_MAX) starve_m++;
            pend_kind = 0;
            if (e_lg && !l_we) begin
                pend_kind = 2;
                pend_data = ref_mem[la_w];
            end else if (e_fg) begin
                pend_kind = 1;
                pend_data = ref_mem[fa_w];
            end
            if (e_lg && l_we) ref_mem[la_w] = l_wdata;
            locked_m = LOCK_EN && l_lock && (lock_now || e_lg);
        end
    end

    initial begin
        bit exp_l;
        bit rl;
        rst = 1'b1; env_clr = 1'b1;
        f_req = 1'b0; f_addr = 32'h0; l_req = 1'b0; l_we = 1'b0;
        l_addr = 32'h0; l_wdata = 32'h0; l_lock = 1'b0;
        @(posedge clk); #1 env_clr = 1'b0;

        // Reset holds grants and responses off even with both requesting.
        applyStimulus(1, 32'h0, 1, 0, 32'h0, 32'h0, 0, 1);
        checkOutput("rst f_gnt", 32'(f_gnt), 32'h0);
        checkOutput("rst l_gnt", 32'(l_gnt), 32'h0);
        checkOutput("rst mem_en", 32'(mem_en), 32'h0);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Fetch-only back-to-back reads.
        applyStimulus(1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("T1 f_gnt", 32'(f_gnt), 32'h1);
        checkOutput("T1 mem_addr0", 32'(mem_addr), 32'h0);
        applyStimulus(1, 32'h4, 0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("T1 mem_addr1", 32'(mem_addr), 32'h1);
        checkOutput("T1 f_rdata0", f_rdata, 32'hC0DE_0000);
        applyStimulus(1, 32'h8, 0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("T1 mem_addr2", 32'(mem_addr), 32'h2);
        checkOutput("T1 f_rdata1", f_rdata, 32'hC1DF_0101);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("T1 f_rvalid2", 32'(f_rvalid), 32'h1);
        checkOutput("T1 f_rdata2", f_rdata, 32'hC2DC_0202);

        // Both requesting continuously: four fetches then one loader grant.
        for (int k = 0; k < 10; k++) begin
            exp_l = (k == 4) || (k == 9);
            applyStimulus(1, 32'h20, 1, 0, 32'h40, 32'h0, 0, 0);
            checkOutput("T2 l_gnt", 32'(l_gnt), 32'(exp_l));
            checkOutput("T2 f_gnt", 32'(f_gnt), 32'(!exp_l));
            checkOutput("T2 fetch_stall", 32'(fetch_stall), 32'(exp_l));
        end

        // Loader write, then fetch of the same word.
        applyStimulus(0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0);
        checkOutput("T3 mem_we", 32'(mem_we), 32'h1);
        checkOutput("T3 mem_addr", 32'(mem_addr), 32'h4);
        applyStimulus(1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("T3 l_rvalid", 32'(l_rvalid), 32'h0);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("T3 f_rdata", f_rdata, 32'hDEAD_BEEF);
        checkOutput("T3 l_rvalid2", 32'(l_rvalid), 32'h0);

        // Out-of-range loader address wraps.
        applyStimulus(0, 32'h0, 1, 0, 32'h1004, 32'h0, 0, 0);
        checkOutput("T4 mem_addr", 32'(mem_addr), 32'h1);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("T4 l_rdata", l_rdata, 32'hC1DF_0101);

        // Reset right after a fetch grant drops the response and clears starvation.
        for (int k = 0; k < 3; k++) applyStimulus(1, 32'h0, 1, 0, 32'h0, 32'h0, 0, 0);
        applyStimulus(1, 32'h8, 0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("T5 f_gnt", 32'(f_gnt), 32'h1);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 1);
        checkOutput("T5 f_rvalid rst", 32'(f_rvalid), 32'h0);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("T5 f_rvalid post", 32'(f_rvalid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 32'h0, 1, 0, 32'h0, 32'h0, 0, 0);
            checkOutput("T5 l_gnt", 32'(l_gnt), 32'(k == 4));
        end

`ifdef IMEM_ARBITER_LOCK_EN
        // Locked loader excludes fetch until l_lock drops.
        applyStimulus(0, 32'h0, 1, 0, 32'h0, 32'h0, 1, 0);
        checkOutput("T6 l_gnt", 32'(l_gnt), 32'h1);
        for (int k = 0; k < 10; k++) begin
            rl = 1'($urandom_range(0, 1));
            applyStimulus(1, 32'h0, rl, 0, 32'h8, 32'h0, 1, 0);
            checkOutput("T6 f_gnt", 32'(f_gnt), 32'h0);
            checkOutput("T6 l_gnt lock", 32'(l_gnt), 32'(rl));
        end
        applyStimulus(1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("T6 f_gnt release", 32'(f_gnt), 32'h1);
`endif

        // Randomized traffic, checked by the per-cycle model.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom,
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                          $urandom, $urandom,
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 99) == 0));
        end
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
